// File: rtl/bounce_sprite_gen.sv
// Test-pattern generator: fixed border and background plus one rectangular sprite that
// bounces inside the border, moving once per frame and changing palette colour on each bounce.
module bounce_sprite_gen #(
  parameter int unsigned H_DISP     = 1280,
  parameter int unsigned V_DISP     = 720,
  parameter int unsigned SIDE_W     = 40,
  parameter int unsigned BLOCK_W    = 40,
  parameter int unsigned BLOCK_H    = 40,
  parameter logic [23:0] BORDER_RGB = 24'h0000FF,
  parameter logic [23:0] BG_RGB     = 24'hFFFFFF
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        frame_start,
  input  logic        pause,
  input  logic [3:0]  step,
  output logic [23:0] pixel_data,
  output logic [7:0]  bounce_cnt,
  output logic        corner_hit
);

  localparam logic signed [11:0] XMin = 12'(SIDE_W);
  localparam logic signed [11:0] XMax = 12'(H_DISP - SIDE_W - BLOCK_W);
  localparam logic signed [11:0] YMin = 12'(SIDE_W);
  localparam logic signed [11:0] YMax = 12'(V_DISP - SIDE_W - BLOCK_H);

  localparam logic [10:0] ResetPos   = 11'(SIDE_W);
  localparam logic [10:0] LeftEdge   = 11'(SIDE_W);
  localparam logic [10:0] RightEdge  = 11'(H_DISP - SIDE_W);
  localparam logic [10:0] BottomEdge = 11'(V_DISP - SIDE_W);
  localparam logic [11:0] BlkW       = 12'(BLOCK_W);
  localparam logic [11:0] BlkH       = 12'(BLOCK_H);

  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
    logic        hit;
  } axis_t;

  logic [10:0] bx_q, bx_d, by_q, by_d;
  logic        hdir_q, hdir_d, vdir_q, vdir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        corner_q, corner_d;
  logic [23:0] pix_q, pix_d;

  logic        move;
  axis_t       ax, ay;
  logic        in_border, in_sprite;
  logic [11:0] x_ext, y_ext, bx_ext, by_ext;

  // Signed 12-bit so a leftward step near the low bound can go below it without wrapping.
  function automatic axis_t axis_move(logic [10:0] pos, logic dir, logic [3:0] stp,
                                      logic signed [11:0] lo, logic signed [11:0] hi);
    logic signed [11:0] cur;
    logic signed [11:0] delta;
    logic signed [11:0] nxt;
    axis_t              r;
    cur   = $signed({1'b0, pos});
    delta = $signed({8'b0, stp});
    nxt   = dir ? cur + delta : cur - delta;
    r.pos = nxt[10:0];
    r.dir = dir;
    r.hit = 1'b0;
    if (dir && (nxt >= hi)) begin
      r.pos = hi[10:0];
      r.dir = 1'b0;
      r.hit = 1'b1;
    end else if (!dir && (nxt <= lo)) begin
      r.pos = lo[10:0];
      r.dir = 1'b1;
      r.hit = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [23:0] palette(logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0: c = 24'h000000;
      3'd1: c = 24'hFF0000;
      3'd2: c = 24'h00FF00;
      3'd3: c = 24'hFF00FF;
      3'd4: c = 24'hFFFF00;
      3'd5: c = 24'h00FFFF;
      3'd6: c = 24'hFF8000;
      3'd7: c = 24'h808080;
    endcase
    return c;
  endfunction

  always_comb begin
    move     = frame_start && !pause && (step != 4'd0);
    ax       = axis_move(bx_q, hdir_q, step, XMin, XMax);
    ay       = axis_move(by_q, vdir_q, step, YMin, YMax);
    bx_d     = bx_q;
    by_d     = by_q;
    hdir_d   = hdir_q;
    vdir_d   = vdir_q;
    cnt_d    = cnt_q;
    corner_d = 1'b0;
    if (move) begin
      bx_d     = ax.pos;
      hdir_d   = ax.dir;
      by_d     = ay.pos;
      vdir_d   = ay.dir;
      // A simultaneous two-axis bounce is one event for the counter.
      if (ax.hit || ay.hit) begin
        cnt_d = cnt_q + 8'd1;
      end
      corner_d = ax.hit && ay.hit;
    end
  end

  always_comb begin
    x_ext     = {1'b0, pixel_xpos};
    y_ext     = {1'b0, pixel_ypos};
    bx_ext    = {1'b0, bx_q};
    by_ext    = {1'b0, by_q};
    in_border = (pixel_xpos < LeftEdge) || (pixel_xpos >= RightEdge) ||
                (pixel_ypos < LeftEdge) || (pixel_ypos >= BottomEdge);
    in_sprite = (x_ext >= bx_ext) && (x_ext < bx_ext + BlkW) &&
                (y_ext >= by_ext) && (y_ext < by_ext + BlkH);
    if (in_border) begin
      pix_d = BORDER_RGB;
    end else if (in_sprite) begin
      pix_d = palette(cnt_q[2:0]);
    end else begin
      pix_d = BG_RGB;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      bx_q     <= ResetPos;
      by_q     <= ResetPos;
      hdir_q   <= 1'b1;
      vdir_q   <= 1'b1;
      cnt_q    <= 8'd0;
      corner_q <= 1'b0;
      pix_q    <= 24'd0;
    end else begin
      bx_q     <= bx_d;
      by_q     <= by_d;
      hdir_q   <= hdir_d;
      vdir_q   <= vdir_d;
      cnt_q    <= cnt_d;
      corner_q <= corner_d;
      pix_q    <= pix_d;
    end
  end

  assign pixel_data = pix_q;
  assign bounce_cnt = cnt_q;
  assign corner_hit = corner_q;

endmodule
